// File: rtl/mx_blk_denorm.sv
// mx_blk_denorm: streaming MX block encoder.
// Collects blk_sz normalised (op, scale) elements, finds the block-wide
// maximum scale among non-zero elements and drains every element aligned
// to that shared scale and narrowed to elem_w bits.
// Optional feature macro: MX_BLK_DENORM_ROUND_EN
//   defined   -> round-to-nearest-even with positive saturation
//   undefined -> plain truncation (floor toward -inf)
module mx_blk_denorm #(
  parameter int int_w   = 24,
  parameter int scale_w = 8,
  parameter int elem_w  = 8,
  parameter int blk_sz  = 32
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [int_w-1:0]   i_op,
  input  logic [scale_w-1:0] i_scale,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [elem_w-1:0]  o_elem,
  output logic [scale_w-1:0] o_shared_scale,
  output logic               o_last
);

  // Extended word: op followed by three guard bits.
  localparam int EW = int_w + 3;
  localparam int CW = (blk_sz > 1) ? $clog2(blk_sz) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(blk_sz - 1);

  typedef enum logic {FILL, DRAIN} state_t;

  state_t state, state_nxt;

  logic [CW-1:0]      cnt;
  logic [scale_w-1:0] max_scale;
  logic               any_nz;

  logic [int_w-1:0]   op_buf    [blk_sz];
  logic [scale_w-1:0] scale_buf [blk_sz];

  logic accept;
  logic out_fire;
  logic at_last;

  logic [int_w-1:0]        cur_op;
  logic [scale_w-1:0]      cur_scale;
  logic [scale_w-1:0]      d;
  logic signed [EW-1:0]    ext_base;
  logic [elem_w-1:0]       cand;
  logic [elem_w-1:0]       elem_val;

  assign accept   = i_valid & o_ready;
  assign out_fire = o_valid & i_ready;
  assign at_last  = (cnt == LAST_IDX);

  // State register: FILL after reset, otherwise follow the next-state logic.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: switch to DRAIN on the final accept, back to FILL after o_last handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (accept && at_last)   state_nxt = DRAIN;
      DRAIN:   if (out_fire && at_last) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  // Element counter and running maximum of non-zero element scales.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt       <= '0;
      max_scale <= '0;
      any_nz    <= 1'b0;
    end else if (state == FILL) begin
      if (accept) begin
        cnt <= cnt + 1'b1;
        if (i_op != '0) begin
          any_nz <= 1'b1;
          if (i_scale > max_scale) max_scale <= i_scale;
        end
      end
    end else if (out_fire) begin
      cnt <= cnt + 1'b1;
      if (at_last) begin
        max_scale <= '0;
        any_nz    <= 1'b0;
      end
    end
  end

  // Block buffer write; contents are only meaningful once a block is complete.
  always_ff @(posedge i_clk) begin
    if (state == FILL && accept) begin
      op_buf[cnt]    <= i_op;
      scale_buf[cnt] <= i_scale;
    end
  end

  assign cur_op    = op_buf[cnt];
  assign cur_scale = scale_buf[cnt];
  assign d         = max_scale - cur_scale;
  assign ext_base  = {cur_op, 3'b000};

`ifdef MX_BLK_DENORM_ROUND_EN
  localparam logic [elem_w-1:0] MAX_POS = {1'b0, {(elem_w-1){1'b1}}};

  logic signed [2*EW-1:0] wide;
  logic signed [2*EW-1:0] wide_sh;
  logic [EW-1:0]          ext;
  logic                   g;
  logic                   rs;
  logic                   inc;

  // Align with sticky capture, then round to nearest even and saturate positive overflow.
  always_comb begin
    wide    = {ext_base, {EW{1'b0}}};
    wide_sh = wide >>> d;
    ext     = wide_sh[2*EW-1:EW];
    ext[0]  = ext[0] | (|wide_sh[EW-1:0]);
    cand    = ext[EW-1 -: elem_w];
    g       = ext[EW-1-elem_w];
    rs      = |ext[EW-2-elem_w:0];
    inc     = g & (rs | cand[0]);
    if (cur_op == '0 || int'(d) >= EW) begin
      elem_val = '0;
    end else if (inc && cand == MAX_POS) begin
      elem_val = MAX_POS;
    end else begin
      elem_val = cand + {{(elem_w-1){1'b0}}, inc};
    end
  end
`else
  logic signed [EW-1:0] ext;

  // Align by arithmetic shift and keep the top elem_w bits (floor).
  always_comb begin
    ext  = ext_base >>> d;
    cand = ext[EW-1 -: elem_w];
    if (cur_op == '0 || int'(d) >= EW) begin
      elem_val = '0;
    end else begin
      elem_val = cand;
    end
  end
`endif

  // Stream outputs derived from state; element data is zero outside DRAIN.
  always_comb begin
    o_ready        = (state == FILL);
    o_valid        = (state == DRAIN);
    o_last         = (state == DRAIN) && at_last;
    o_shared_scale = any_nz ? max_scale : '0;
    o_elem         = (state == DRAIN) ? elem_val : '0;
  end

endmodule

// File: tb/tb_mx_blk_denorm.sv
// tb_mx_blk_denorm: directed and randomized checks of mx_blk_denorm with
// blk_sz=4 against an arithmetic reference model (value = op * 2^scale).
// Honours MX_BLK_DENORM_ROUND_EN in the same way as the design.
module tb_mx_blk_denorm;

  localparam int INT_W   = 24;
  localparam int SCALE_W = 8;
  localparam int ELEM_W  = 8;
  localparam int BLK     = 4;

  logic               i_clk = 1'b0;
  logic               i_rst_n;
  logic               i_valid;
  logic               o_ready;
  logic [INT_W-1:0]   i_op;
  logic [SCALE_W-1:0] i_scale;
  logic               o_valid;
  logic               i_ready;
  logic [ELEM_W-1:0]  o_elem;
  logic [SCALE_W-1:0] o_shared_scale;
  logic               o_last;

  int n_vec  = 0;
  int n_fail = 0;

  logic [INT_W-1:0]   blk_op [BLK];
  logic [SCALE_W-1:0] blk_sc [BLK];

  mx_blk_denorm #(
    .int_w(INT_W), .scale_w(SCALE_W), .elem_w(ELEM_W), .blk_sz(BLK)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_op(i_op), .i_scale(i_scale), .o_valid(o_valid), .i_ready(i_ready),
    .o_elem(o_elem), .o_shared_scale(o_shared_scale), .o_last(o_last)
  );

  // Free-running clock, 10 time units per period.
  always #5 i_clk = ~i_clk;

  // One comparison: counts it and reports a failure through an immediate assertion.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Shared scale: largest scale among non-zero elements, 0 if none.
  function automatic logic [SCALE_W-1:0] model_shared();
    logic [SCALE_W-1:0] m;
    m = '0;
    for (int i = 0; i < BLK; i++)
      if (blk_op[i] != '0 && blk_sc[i] > m) m = blk_sc[i];
    return m;
  endfunction

  // Element = op * 2^(scale-shared) expressed in units of 2^(int_w-elem_w), rounded or floored.
  function automatic logic [ELEM_W-1:0] model_elem(input logic [INT_W-1:0] op,
                                                    input logic [SCALE_W-1:0] sc,
                                                    input logic [SCALE_W-1:0] sh);
    int     d;
    int     k;
    longint v;
    longint q;
    longint rem;
    longint half;
    d = int'(sh) - int'(sc);
    if (op == '0 || d >= INT_W + 3) return '0;
    k = d + INT_W - ELEM_W;
    v = longint'($signed(op));
    q = v >>> k;
`ifdef MX_BLK_DENORM_ROUND_EN
    rem  = v - (q <<< k);
    half = 64'sd1 <<< (k - 1);
    if (rem > half || (rem == half && q[0])) q = q + 1;
    if (q > 127) q = 127;
`else
    rem  = 0;
    half = 0;
`endif
    return q[ELEM_W-1:0];
  endfunction

  // Feed the first n entries of the block table, one accept per cycle, from a negedge.
  task automatic applyStimulus(input int n, input bit hold_valid);
    for (int i = 0; i < n; i++) begin
      i_valid = 1'b1;
      i_op    = blk_op[i];
      i_scale = blk_sc[i];
      checkOutput("fill_ready", 32'(o_ready), 32'd1);
      checkOutput("fill_valid", 32'(o_valid), 32'd0);
      @(negedge i_clk);
    end
    if (!hold_valid) i_valid = 1'b0;
  endtask

  // Drain n_drain elements, optionally stalling i_ready for stall_len cycles at element stall_at.
  task automatic drainBlock(input int n_drain, input int stall_at, input int stall_len);
    logic [SCALE_W-1:0] sh;
    logic [ELEM_W-1:0]  ex;
    logic               saved_valid;
    sh = model_shared();
    for (int j = 0; j < n_drain; j++) begin
      ex = model_elem(blk_op[j], blk_sc[j], sh);
      checkOutput("drain_valid",  32'(o_valid), 32'd1);
      checkOutput("drain_ready",  32'(o_ready), 32'd0);
      checkOutput("drain_last",   32'(o_last),  32'(j == BLK - 1));
      checkOutput("drain_shared", 32'(o_shared_scale), 32'(sh));
      checkOutput("drain_elem",   32'(o_elem),  32'(ex));
      if (j == stall_at) begin
        saved_valid = i_valid;
        i_ready = 1'b0;
        i_valid = 1'b1;
        for (int s = 0; s < stall_len; s++) begin
          i_op    = 24'($urandom);
          i_scale = 8'($urandom_range(0, 60));
          @(negedge i_clk);
          checkOutput("stall_elem",   32'(o_elem),  32'(ex));
          checkOutput("stall_last",   32'(o_last),  32'(j == BLK - 1));
          checkOutput("stall_shared", 32'(o_shared_scale), 32'(sh));
          checkOutput("stall_ready",  32'(o_ready), 32'd0);
        end
        i_ready = 1'b1;
        i_valid = saved_valid;
      end
      @(negedge i_clk);
    end
    if (n_drain == BLK) begin
      checkOutput("post_valid", 32'(o_valid), 32'd0);
      checkOutput("post_ready", 32'(o_ready), 32'd1);
      checkOutput("post_shared", 32'(o_shared_scale), 32'd0);
    end
  endtask

  // Asynchronous reset between edges, with immediate output checks.
  task automatic doReset();
    #2;
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    #1;
    checkOutput("rst_valid",  32'(o_valid), 32'd0);
    checkOutput("rst_ready",  32'(o_ready), 32'd1);
    checkOutput("rst_last",   32'(o_last),  32'd0);
    checkOutput("rst_elem",   32'(o_elem),  32'd0);
    checkOutput("rst_shared", 32'(o_shared_scale), 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  task automatic setBlock(input logic [INT_W-1:0] o0, input logic [SCALE_W-1:0] s0,
                          input logic [INT_W-1:0] o1, input logic [SCALE_W-1:0] s1,
                          input logic [INT_W-1:0] o2, input logic [SCALE_W-1:0] s2,
                          input logic [INT_W-1:0] o3, input logic [SCALE_W-1:0] s3);
    blk_op[0] = o0; blk_sc[0] = s0;
    blk_op[1] = o1; blk_sc[1] = s1;
    blk_op[2] = o2; blk_sc[2] = s2;
    blk_op[3] = o3; blk_sc[3] = s3;
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_op    = '0;
    i_scale = '0;
    @(negedge i_clk);
    doReset();

    // Basic alignment: shared 10, elements 0x40,0x40,0x20,0x08.
    setBlock(24'h400000, 8'd10, 24'h400000, 8'd10, 24'h400000, 8'd9, 24'h400000, 8'd7);
    applyStimulus(BLK, 1'b0);
    checkOutput("tp_shared", 32'(o_shared_scale), 32'd10);
    checkOutput("tp_elem0", 32'(o_elem), 32'h40);
    drainBlock(BLK, -1, 0);

    // Rounding cases at equal scale, with backpressure on element 1.
    setBlock(24'h418000, 8'd12, 24'h408000, 8'd12, 24'h7FFFFF, 8'd12, 24'h400000, 8'd12);
    applyStimulus(BLK, 1'b0);
`ifdef MX_BLK_DENORM_ROUND_EN
    checkOutput("tp_tie_even", 32'(o_elem), 32'h42);
`else
    checkOutput("tp_trunc", 32'(o_elem), 32'h41);
`endif
    drainBlock(BLK, 1, 5);

    // Negative elements at a common scale.
    setBlock(24'hC00000, 8'd20, 24'hC00000, 8'd20, 24'h400000, 8'd20, 24'h000000, 8'd20);
    applyStimulus(BLK, 1'b0);
    checkOutput("tp_neg", 32'(o_elem), 32'hC0);
    drainBlock(BLK, -1, 0);

    // Underflow at d=27; a zero element at a higher scale is ignored.
    setBlock(24'hC00000, 8'd20, 24'h400000, 8'd47, 24'hC00000, 8'd46, 24'h000000, 8'd60);
    applyStimulus(BLK, 1'b0);
    checkOutput("tp_uflow_shared", 32'(o_shared_scale), 32'd47);
    checkOutput("tp_uflow_elem", 32'(o_elem), 32'h00);
    drainBlock(BLK, -1, 0);

    // All-zero block.
    setBlock(24'h0, 8'd33, 24'h0, 8'd5, 24'h0, 8'd90, 24'h0, 8'd1);
    applyStimulus(BLK, 1'b0);
    drainBlock(BLK, 2, 3);

    // Reset mid-fill, then a block with its own max of 5.
    setBlock(24'h400000, 8'd30, 24'h400000, 8'd30, 24'h0, 8'd0, 24'h0, 8'd0);
    applyStimulus(2, 1'b0);
    doReset();
    setBlock(24'h400000, 8'd5, 24'h200000, 8'd3, 24'hA00000, 8'd4, 24'h123456, 8'd5);
    applyStimulus(BLK, 1'b0);
    checkOutput("rst_fill_shared", 32'(o_shared_scale), 32'd5);
    drainBlock(BLK, -1, 0);

    // Reset mid-drain: no output until a fresh full block.
    setBlock(24'h400000, 8'd30, 24'h300000, 8'd28, 24'hF00000, 8'd29, 24'h000100, 8'd30);
    applyStimulus(BLK, 1'b0);
    drainBlock(2, -1, 0);
    doReset();
    for (int c = 0; c < 3; c++) begin
      checkOutput("rst_drain_idle", 32'(o_valid), 32'd0);
      @(negedge i_clk);
    end
    setBlock(24'h7FFFFF, 8'd2, 24'h800000, 8'd2, 24'h010000, 8'd1, 24'h400000, 8'd0);
    applyStimulus(BLK, 1'b0);
    drainBlock(BLK, -1, 0);

    // Back-to-back blocks with i_valid held high through the drain.
    setBlock(24'h400000, 8'd30, 24'h400000, 8'd25, 24'h400000, 8'd29, 24'h400000, 8'd30);
    applyStimulus(BLK, 1'b1);
    drainBlock(BLK, -1, 0);
    setBlock(24'h400000, 8'd5, 24'h400000, 8'd4, 24'h400000, 8'd2, 24'h400000, 8'd5);
    applyStimulus(BLK, 1'b0);
    checkOutput("b2b_shared", 32'(o_shared_scale), 32'd5);
    drainBlock(BLK, -1, 0);

    // Randomized blocks with occasional stalls.
    for (int b = 0; b < 25; b++) begin
      for (int i = 0; i < BLK; i++) begin
        blk_op[i] = ($urandom_range(0, 5) == 0) ? 24'h0 : 24'($urandom);
        blk_sc[i] = 8'($urandom_range(0, 40));
      end
      applyStimulus(BLK, 1'b0);
      if ($urandom_range(0, 2) == 0)
        drainBlock(BLK, int'($urandom_range(0, BLK - 1)), int'($urandom_range(1, 4)));
      else
        drainBlock(BLK, -1, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
